// File: rtl/chess_piece_render_if.sv
// Pixel-in / board-RAM / classified-pixel-out bundle for chess_piece_render.
// master = raster source, RAM and colour mux side; slave = the renderer.
interface chess_piece_render_if;
    logic       pix_valid;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] cell_addr;
    logic       cell_rd_en;
    logic [1:0] cell_data;
    logic       out_valid;
    logic [9:0] out_x;
    logic [9:0] out_y;
    logic       piece_hit;
    logic       piece_white;
    logic       cursor_hit;
    logic       last_hit;

    modport master (
        output pix_valid, x, y, cell_data,
        input  cell_addr, cell_rd_en, out_valid, out_x, out_y,
               piece_hit, piece_white, cursor_hit, last_hit
    );

    modport slave (
        input  pix_valid, x, y, cell_data,
        output cell_addr, cell_rd_en, out_valid, out_x, out_y,
               piece_hit, piece_white, cursor_hit, last_hit
    );
endinterface

// File: rtl/chess_piece_render.sv
// 3-stage renderer: nearest intersection -> board RAM lookup -> piece/cursor/last-move hit.
// Optional macro CHESS_BLINK_EN blinks the last-move piece off every 2^(BLINK_LOG2-1) frames.
module chess_piece_render #(
    parameter int BOARD_N    = 15,
    parameter int GRID       = 31,
    parameter int X0         = 102,
    parameter int Y0         = 23,
    parameter int RADIUS     = 15,
    parameter int RING_W     = 3,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chess_piece_render_if.slave  bus,
    input  logic                 frame_start,
    input  logic [3:0]           cursor_row,
    input  logic [3:0]           cursor_col,
    input  logic [3:0]           last_row,
    input  logic [3:0]           last_col,
    input  logic                 last_valid
);
    localparam int HALF = GRID / 2;
    localparam int X_LO = X0 - HALF;
    localparam int X_HI = X0 + (BOARD_N - 1) * GRID + HALF;
    localparam int Y_LO = Y0 - HALF;
    localparam int Y_HI = Y0 + (BOARD_N - 1) * GRID + HALF;
    localparam logic [19:0] R2_OUT = 20'(RADIUS * RADIUS);
    localparam logic [19:0] R2_IN  = 20'((RADIUS - RING_W) * (RADIUS - RING_W));

    // ---------------- stage 1: nearest intersection ----------------
    logic signed [10:0] dx, dy, ox_d, oy_d;
    logic [3:0]         col_d, row_d;
    logic               in_board_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dx    = $signed(11'({1'b0, bus.x}) - 11'(X0));
        dy    = $signed(11'({1'b0, bus.y}) - 11'(Y0));
        col_d = '0;
        row_d = '0;
        // Thresholds rise with k, so counting passes yields the nearest index, clamped.
        for (int k = 1; k < BOARD_N; k++) begin
            if (dx >= $signed(11'(k * GRID - HALF))) col_d = col_d + 4'd1;
            if (dy >= $signed(11'(k * GRID - HALF))) row_d = row_d + 4'd1;
        end
        ox_d       = dx - $signed(11'(int'(col_d) * GRID));
        oy_d       = dy - $signed(11'(int'(row_d) * GRID));
        in_board_d = (int'(bus.x) >= X_LO) && (int'(bus.x) <= X_HI) &&
                     (int'(bus.y) >= Y_LO) && (int'(bus.y) <= Y_HI);
    end

    logic               v1_q, inb1_q;
    logic [3:0]         row_q, col_q;
    logic signed [10:0] ox_q, oy_q;
    logic [9:0]         x1_q, y1_q;

    // ---------------- stage 2: distance and cell matches ----------------
    logic [10:0] ax, ay;
    logic [21:0] sq_x, sq_y;
    logic [19:0] d2_d;
    logic        cur_m_d, last_m_d;

    always_comb begin
        ax       = ox_q[10] ? 11'(-ox_q) : 11'(ox_q);
        ay       = oy_q[10] ? 11'(-oy_q) : 11'(oy_q);
        sq_x     = 22'(ax) * 22'(ax);
        sq_y     = 22'(ay) * 22'(ay);
        d2_d     = 20'(sq_x + sq_y);
        cur_m_d  = (row_q == cursor_row) && (col_q == cursor_col);
        last_m_d = last_valid && (row_q == last_row) && (col_q == last_col);
    end

    assign bus.cell_addr  = 8'(int'(row_q) * BOARD_N + int'(col_q));
    assign bus.cell_rd_en = v1_q;

    logic        v2_q, inb2_q, cur_m_q, last_m_q;
    logic [19:0] d2_q;
    logic [9:0]  x2_q, y2_q;

    // ---------------- stage 3: classification ----------------
    logic suppress;

`ifdef CHESS_BLINK_EN
    logic [BLINK_LOG2-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           frame_cnt_q <= '0;
        else if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
    end

    assign suppress = frame_cnt_q[BLINK_LOG2-1] && last_m_q;
`else
    logic [BLINK_LOG2-1:0] unused_frame_start;
    assign unused_frame_start = {BLINK_LOG2{frame_start}};
    assign suppress           = 1'b0;
`endif

    logic occ, piece_raw, piece_d, white_d, cursor_d, last_d;

    always_comb begin
        occ       = (bus.cell_data == 2'b01) || (bus.cell_data == 2'b10);
        piece_raw = v2_q && inb2_q && occ && (d2_q < R2_OUT);
        piece_d   = piece_raw && !suppress;
        white_d   = piece_d && (bus.cell_data == 2'b10);
        cursor_d  = v2_q && inb2_q && cur_m_q && (d2_q >= R2_IN) && (d2_q < R2_OUT);
        last_d    = piece_raw && last_m_q;
    end

    logic       out_valid_q, piece_hit_q, piece_white_q, cursor_hit_q, last_hit_q;
    logic [9:0] out_x_q, out_y_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q          <= 1'b0;
            inb1_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            v2_q          <= 1'b0;
            inb2_q        <= 1'b0;
            cur_m_q       <= 1'b0;
            last_m_q      <= 1'b0;
            d2_q          <= '0;
            x2_q          <= '0;
            y2_q          <= '0;
            out_valid_q   <= 1'b0;
            piece_hit_q   <= 1'b0;
            piece_white_q <= 1'b0;
            cursor_hit_q  <= 1'b0;
            last_hit_q    <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
        end else begin
            v1_q          <= bus.pix_valid;
            inb1_q        <= in_board_d;
            row_q         <= row_d;
            col_q         <= col_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            x1_q          <= bus.x;
            y1_q          <= bus.y;
            v2_q          <= v1_q;
            inb2_q        <= inb1_q;
            cur_m_q       <= cur_m_d;
            last_m_q      <= last_m_d;
            d2_q          <= d2_d;
            x2_q          <= x1_q;
            y2_q          <= y1_q;
            out_valid_q   <= v2_q;
            piece_hit_q   <= piece_d;
            piece_white_q <= white_d;
            cursor_hit_q  <= cursor_d;
            last_hit_q    <= last_d;
            out_x_q       <= x2_q;
            out_y_q       <= y2_q;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.piece_hit   = piece_hit_q;
    assign bus.piece_white = piece_white_q;
    assign bus.cursor_hit  = cursor_hit_q;
    assign bus.last_hit    = last_hit_q;
endmodule

// File: doc/chess_piece_render.md
Name: chess_piece_render

Overview:
- Pipelined, parametrised successor to the single-intersection piece test.
- Takes the raster pixel stream (x, y) from the VGA timing block and finds the nearest board intersection.
- Reads that cell from the board-state RAM, then classifies the pixel as piece, cursor ring and/or last-move marker.
- Sits between the VGA sync generator and the colour mux; fixed 3-cycle latency.

Parameters:
- BOARD_N, 15, intersections per side (2..16).
- GRID, 31, pixel pitch between intersections.
- X0, 102, pixel x of column 0.
- Y0, 23, pixel y of row 0.
- RADIUS, 15, piece radius; hit when dx²+dy² < RADIUS².
- RING_W, 3, cursor ring width; ring when (RADIUS-RING_W)² <= d² < RADIUS².
- BLINK_LOG2, 5, last-move blink half-period = 2^(BLINK_LOG2-1) frames.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  x/y valid this cycle.
- x  in  10  pixel column.
- y  in  10  pixel row.
- frame_start  in  1  one-cycle pulse at start of each frame.
- cursor_row  in  4  cursor intersection row.
- cursor_col  in  4  cursor intersection column; quasi-static.
- last_row  in  4  last-move intersection row.
- last_col  in  4  last-move intersection column.
- last_valid  in  1  a last move exists.
- cell_addr  out  8  row*BOARD_N+col, driven from stage-1 registers.
- cell_rd_en  out  1  equals stage-1 valid.
- cell_data  in  2  RAM data, registered, returned one cycle after cell_addr: 00 empty, 01 black, 10 white, 11 treated as empty.
- out_valid  out  1  outputs below are valid.
- out_x  out  10  x delayed to match outputs.
- out_y  out  10  y delayed to match outputs.
- piece_hit  out  1  pixel inside an occupied cell's disc.
- piece_white  out  1  colour of that piece; 0 when piece_hit=0.
- cursor_hit  out  1  pixel on the cursor ring, regardless of occupancy.
- last_hit  out  1  pixel inside the disc at the last-move cell while occupied.

Behaviour:
- Reset (async assert, sync deassert by the clk domain): all pipeline valids 0; every output 0; frame counter 0.
- Reset asserted mid-stream flushes the pipeline; no partial outputs after release.
- Stage 1 (edge n):
  - dx = x-X0 and dy = y-Y0, signed 11-bit.
  - col = count of k in 1..BOARD_N-1 with dx >= k*GRID - GRID/2 (integer GRID/2). row likewise from dy.
  - ox = dx - col*GRID and oy = dy - row*GRID, signed.
  - in_board = X0-GRID/2 <= x <= X0+(BOARD_N-1)*GRID+GRID/2, and the same test on y.
  - Register row, col, ox, oy, in_board, x, y, valid.
- Stage 2 (edge n+1):
  - cell_addr/cell_rd_en are presented from the stage-1 registers.
  - Register d2 = ox²+oy² (20-bit unsigned), cur_m = (row,col)==cursor, last_m = last_valid && (row,col)==last.
- Stage 3 (edge n+2):
  - cell_data is valid this cycle. occ = cell_data is 01 or 10.
  - piece_hit = valid && in_board && occ && d2 < RADIUS².
  - cursor_hit = valid && in_board && cur_m && (RADIUS-RING_W)² <= d2 < RADIUS².
  - last_hit = piece_hit && last_m.
  - All outputs registered. Pixel sampled at edge n appears after edge n+2; out_valid mirrors pix_valid with 3-cycle delay.
- Boundary conditions:
  - d2 == RADIUS² is a miss.
  - Outside the board: all hits 0; cell_addr still issued (row/col clamp to 0 or BOARD_N-1).
  - pix_valid=0 bubbles propagate; outputs are 0 with out_valid=0.
- Frame counter (BLINK_LOG2 bits):
  - Increments on each sampled frame_start and wraps.
  - blink_off = cnt[BLINK_LOG2-1].
  - frame_start coincident with pix_valid is legal and does not disturb the pipeline.

Optional Feature:
- CHESS_BLINK_EN defined: when blink_off=1, piece_hit and piece_white are forced 0 for pixels where last_m=1; last_hit is still reported.
- Undefined: the frame counter is not built and frame_start is ignored; pieces are never suppressed.

Test Plan:
- Cell (0,0)=01, x=102,y=23 valid -> 3 cycles later out_valid=1, piece_hit=1, piece_white=0, cell_addr was 0.
- Cell (0,0)=10: x=116,y=23 -> piece_hit=1, white=1 (d2=196). x=117,y=23 -> piece_hit=0 (d2=225, boundary).
- Cursor (7,7), cell empty, x=333,y=240 -> cursor_hit=1 (d2=196 in [144,225)), piece_hit=0. x=319,y=240 -> cursor_hit=0.
- x=80,y=240 and cell data 01 -> all hits 0 (outside board). cell_data=11 at centre -> piece_hit=0.
- CHESS_BLINK_EN, last=(3,4) occupied, BLINK_LOG2=5 -> frames 0-15 piece_hit=1 at (226,116); after 16 frame_start pulses piece_hit=0, last_hit=1.
- Stream 10 valid pixels, drop rst_n on the 5th -> outputs 0 immediately. After release, first out_valid occurs 3 cycles after the next valid pixel.
